ddr2_wdf_rd_sched: RTL and testbench
====================================

# ddr2_wdf_rd_sched

Write-data read scheduler for the DDR2 16-bit write path. Tracks how many 36-bit words (32 data + 4 mask) the user has pushed into the write data FIFO, accepts write-burst commands from the main controller FSM, and for each one issues a contiguous train of `ctrl_wdf_rden` pulses after a programmable write-latency delay. The block sits in the clk0 domain between the controller FSM and the write data FIFO's read-enable input, and paces reads so the FIFO is never read while empty.

## Interface
Parameters:
- `DEPTH`, 512: FIFO capacity in words; occupancy saturates here.
- `CNT_W`, 10: width of the occupancy counter; must hold `DEPTH`.
- `WLAT`, 2: clk0 cycles from entering LAT to the first `ctrl_wdf_rden`; legal range 0..15.
- `ARR_DLY`, 3: clk0 cycles a FIFO write is delayed before it counts as readable (covers the FIFO's empty-flag crossing latency); legal range 1..7.

Ports:
- `clk0`, in, 1: sole clock, rising edge.
- `rst_n`, in, 1: asynchronous active-low reset.
- `app_wdf_wren`, in, 1: copy of the FIFO write enable; one word written per high cycle.
- `wr_cmd_valid`, in, 1: write-burst request from the controller.
- `wr_cmd_bl8`, in, 1: sampled on accept; 1 = BL8 (4 words), 0 = BL4 (2 words).
- `wr_cmd_ready`, out, 1: scheduler can accept a command.
- `ctrl_wdf_rden`, out, 1: FIFO read enable, registered.
- `wr_burst_done`, out, 1: one-cycle pulse after the last read of a burst.
- `wr_busy`, out, 1: high whenever the state is not IDLE.
- `wdf_words`, out, CNT_W: readable word count (arrived minus read).
- `wdf_err`, out, 1: sticky overflow flag (see Configuration).

## Operation
- Arrival pipeline: `app_wdf_wren` passes through an ARR_DLY-stage shift register. The delayed output `wren_arr` increments `wdf_words`.
- Counter update each cycle: `+wren_arr − ctrl_wdf_rden`. If both are high, the count is unchanged. An increment at `DEPTH` saturates and sets the overflow condition. A decrement at 0 cannot occur by construction.
- `need` is a 3-bit register loaded on accept with 2 or 4. `beat` is a 3-bit down-counter. `lat` is a 4-bit down-counter.
- States:
  - IDLE: `wr_cmd_ready`=1. On `wr_cmd_valid`, load `need`, go to WAIT.
  - WAIT: stay while `wdf_words < need`. Otherwise load `lat`=WLAT and go to LAT, or go directly to BURST if WLAT=0.
  - LAT: decrement `lat`. At 0, load `beat`=`need` and go to BURST.
  - BURST: drive `ctrl_wdf_rden`=1 and decrement `beat`. After `need` consecutive cycles, go to IDLE and pulse `wr_burst_done`.
- Only one command is outstanding at a time. `wr_cmd_ready` is combinational from the state (IDLE).
- Reads in BURST are never gapped. Data sufficiency is checked only in WAIT, and no other consumer exists.
- Arrivals during LAT or BURST are counted normally.

## Timing
- Reset values: `ctrl_wdf_rden`=0, `wr_burst_done`=0, `wr_busy`=0, `wdf_words`=0, `wdf_err`=0, `wr_cmd_ready`=1, state IDLE, arrival pipe cleared. Assertion is immediate (asynchronous); deassertion is taken on the next clk0 edge.
- Reset mid-burst aborts the burst, drops `ctrl_wdf_rden` at once, and discards the arrival pipe.
- Accept at edge T with data already sufficient:
  - WAIT at T+1.
  - LAT from T+2.
  - First `ctrl_wdf_rden` at T+2+WLAT (at T+2 when WLAT=0).
- Burst length: `ctrl_wdf_rden` is high for exactly 2 (BL4) or 4 (BL8) consecutive cycles.
- `wr_burst_done` is high in the cycle after the last rden. IDLE and ready are asserted that same cycle.
- A write at cycle W becomes visible in `wdf_words` at W+ARR_DLY+1.
- Back-to-back commands: a new accept is possible in the `wr_burst_done` cycle.

## Configuration
- `WDF_OVF_CHK_EN`
  - Defined: `wdf_err` is set when `wren_arr`=1, `ctrl_wdf_rden`=0 and `wdf_words`=DEPTH. It stays set until reset.
  - Undefined: `wdf_err` is tied to 0 and the check logic is not built. Saturation still applies.

## Test plan
- Reset then idle: `wdf_words`=0, `wr_cmd_ready`=1, no rden for 20 cycles.
- 4 writes, then a BL8 command, WLAT=2:
  - `wdf_words` reaches 4 at write+4.
  - rden high for 4 cycles starting 4 cycles after accept.
  - done pulses once; `wdf_words` returns to 0.
- BL4 command issued before any data: stays in WAIT. Feed 1 word, still waits. Feed a 2nd word: rden ×2 begins WLAT+1 cycles after `wdf_words`=2.
- Continuous writes during a BL8 burst: simultaneous wren_arr/rden cycles leave the count unchanged; the final count equals writes − 4.
- Assert `rst_n` low in the 2nd rden cycle: rden drops asynchronously, all outputs return to reset values, and no done pulse is generated.
- With `WDF_OVF_CHK_EN`, DEPTH=8: 9 writes with no reads give `wdf_words`=8 and `wdf_err`=1, sticky until reset. Without the macro, `wdf_err` stays 0.

Source files
------------

// File: rtl/ddr2_wdf_rd_sched.sv
// rtl/ddr2_wdf_rd_sched.sv - paces write-data FIFO reads for DDR2 write bursts.
// Optional overflow check: define WDF_OVF_CHK_EN to build the sticky wdf_err flag.
module ddr2_wdf_rd_sched #(
  parameter int DEPTH   = 512,
  parameter int CNT_W   = 10,
  parameter int WLAT    = 2,
  parameter int ARR_DLY = 3
) (
  input  logic             clk0,
  input  logic             rst_n,
  input  logic             app_wdf_wren,
  input  logic             wr_cmd_valid,
  input  logic             wr_cmd_bl8,
  output logic             wr_cmd_ready,
  output logic             ctrl_wdf_rden,
  output logic             wr_burst_done,
  output logic             wr_busy,
  output logic [CNT_W-1:0] wdf_words,
  output logic             wdf_err
);

  typedef enum logic [1:0] {IDLE, WAIT, LAT, BURST} state_t;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [3:0]       WLAT_C  = 4'(WLAT);

  state_t             state_q, state_d;
  logic [ARR_DLY-1:0] arr_q, arr_d;
  logic [CNT_W-1:0]   words_q, words_d;
  logic [2:0]         need_q, need_d;
  logic [2:0]         beat_q, beat_d;
  logic [3:0]         lat_q, lat_d;
  logic               rden_q, rden_d;
  logic               done_q, done_d;
  logic               wren_arr;
  logic               have_data;

  assign wren_arr  = arr_q[ARR_DLY-1];
  assign have_data = (words_q >= {{(CNT_W-3){1'b0}}, need_q});

  // State register
  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic, together with the burst bookkeeping counters
  always_comb begin
    state_d = state_q;
    need_d  = need_q;
    beat_d  = beat_q;
    lat_d   = lat_q;
    unique case (state_q)
      IDLE: begin
        if (wr_cmd_valid) begin
          need_d  = wr_cmd_bl8 ? 3'd4 : 3'd2;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (have_data) begin
          if (WLAT == 0) begin
            beat_d  = need_q;
            state_d = BURST;
          end else begin
            lat_d   = WLAT_C;
            state_d = LAT;
          end
        end
      end
      LAT: begin
        lat_d = lat_q - 4'd1;
        // LAT occupies exactly WLAT cycles, so leave while the last count is consumed
        if (lat_q <= 4'd1) begin
          beat_d  = need_q;
          state_d = BURST;
        end
      end
      BURST: begin
        beat_d = beat_q - 3'd1;
        if (beat_q == 3'd1) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic decoded from the current state
  always_comb begin
    wr_cmd_ready = (state_q == IDLE);
    wr_busy      = (state_q != IDLE);
  end

  // Arrival pipe, occupancy count and registered strobes
  always_comb begin
    arr_d   = (arr_q << 1) | ARR_DLY'(app_wdf_wren);
    words_d = words_q;
    if (wren_arr && !rden_q) begin
      if (words_q != DEPTH_C) begin
        words_d = words_q + CNT_W'(1);
      end
    end else if (!wren_arr && rden_q) begin
      words_d = words_q - CNT_W'(1);
    end
    rden_d = (state_d == BURST);
    done_d = (state_q == BURST) && (state_d == IDLE);
  end

  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      arr_q   <= '0;
      words_q <= '0;
      need_q  <= 3'd0;
      beat_q  <= 3'd0;
      lat_q   <= 4'd0;
      rden_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      arr_q   <= arr_d;
      words_q <= words_d;
      need_q  <= need_d;
      beat_q  <= beat_d;
      lat_q   <= lat_d;
      rden_q  <= rden_d;
      done_q  <= done_d;
    end
  end

  assign ctrl_wdf_rden = rden_q;
  assign wr_burst_done = done_q;
  assign wdf_words     = words_q;

`ifdef WDF_OVF_CHK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q | (wren_arr & ~rden_q & (words_q == DEPTH_C));
  end

  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign wdf_err = err_q;
`else
  assign wdf_err = 1'b0;
`endif

endmodule

// File: tb/tb_ddr2_wdf_rd_sched.sv
// tb/tb_ddr2_wdf_rd_sched.sv - directed-vector bench for ddr2_wdf_rd_sched.
module tb_ddr2_wdf_rd_sched;

  localparam int CNT_W = 4;

  logic             clk0 = 1'b0;
  logic             rst_n = 1'b0;
  logic             app_wdf_wren = 1'b0;
  logic             wr_cmd_valid = 1'b0;
  logic             wr_cmd_bl8 = 1'b0;
  logic             wr_cmd_ready;
  logic             ctrl_wdf_rden;
  logic             wr_burst_done;
  logic             wr_busy;
  logic [CNT_W-1:0] wdf_words;
  logic             wdf_err;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] rden_mask;
  logic [15:0] done_mask;
  logic        seen;
  logic        exp_err;

  ddr2_wdf_rd_sched #(
    .DEPTH(8), .CNT_W(CNT_W), .WLAT(2), .ARR_DLY(3)
  ) dut (
    .clk0(clk0), .rst_n(rst_n), .app_wdf_wren(app_wdf_wren),
    .wr_cmd_valid(wr_cmd_valid), .wr_cmd_bl8(wr_cmd_bl8),
    .wr_cmd_ready(wr_cmd_ready), .ctrl_wdf_rden(ctrl_wdf_rden),
    .wr_burst_done(wr_burst_done), .wr_busy(wr_busy),
    .wdf_words(wdf_words), .wdf_err(wdf_err)
  );

  always #5 clk0 = ~clk0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk0);
    #1;
  endtask

  // Samples k = 1..n cycles after the current one into the bit masks
  task automatic record(input int n);
    rden_mask = '0;
    done_mask = '0;
    for (int k = 1; k <= n; k++) begin
      rden_mask[k] = ctrl_wdf_rden;
      done_mask[k] = wr_burst_done;
      tick();
    end
  endtask

  task automatic accept(input logic bl8);
    wr_cmd_valid = 1'b1;
    wr_cmd_bl8   = bl8;
    check("ready_at_accept", wr_cmd_ready, 1);
    tick();
    wr_cmd_valid = 1'b0;
  endtask

  initial begin
`ifdef WDF_OVF_CHK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    // Reset then idle
    repeat (3) tick();
    check("rst_words", wdf_words, 0);
    check("rst_ready", wr_cmd_ready, 1);
    check("rst_rden", ctrl_wdf_rden, 0);
    check("rst_done", wr_burst_done, 0);
    check("rst_busy", wr_busy, 0);
    check("rst_err", wdf_err, 0);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      seen |= ctrl_wdf_rden;
      tick();
    end
    check("idle_no_rden", seen, 0);
    check("idle_ready", wr_cmd_ready, 1);

    // Four writes, then BL8: count lands at last write + 4, reads at accept + 4
    for (int i = 0; i < 4; i++) begin
      app_wdf_wren = 1'b1;
      tick();
    end
    app_wdf_wren = 1'b0;
    tick(); tick();
    check("arr_words_w3p3", wdf_words, 3);
    tick();
    check("arr_words_w3p4", wdf_words, 4);
    accept(1'b1);
    check("bl8_busy", wr_busy, 1);
    check("bl8_wait_ready", wr_cmd_ready, 0);
    record(12);
    check("bl8_rden_mask", rden_mask, 16'h00F0);
    check("bl8_done_mask", done_mask, 16'h0100);
    check("bl8_words_end", wdf_words, 0);
    check("bl8_ready_end", wr_cmd_ready, 1);

    // BL4 before any data: hold in WAIT until the second word arrives
    accept(1'b0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      seen |= ctrl_wdf_rden;
      tick();
    end
    check("bl4_wait_no_rden", seen, 0);
    check("bl4_wait_busy", wr_busy, 1);
    app_wdf_wren = 1'b1;
    tick();
    app_wdf_wren = 1'b0;
    for (int i = 0; i < 8; i++) begin
      seen |= ctrl_wdf_rden;
      tick();
    end
    check("bl4_one_word_no_rden", seen, 0);
    check("bl4_one_word_count", wdf_words, 1);
    app_wdf_wren = 1'b1;
    tick();
    app_wdf_wren = 1'b0;
    record(12);
    check("bl4_rden_mask", rden_mask, 16'h0180);
    check("bl4_done_mask", done_mask, 16'h0200);
    check("bl4_words_end", wdf_words, 0);

    // Continuous writes overlapping a BL8 burst
    for (int i = 0; i < 4; i++) begin
      app_wdf_wren = 1'b1;
      tick();
    end
    app_wdf_wren = 1'b0;
    repeat (4) tick();
    check("ovl_pre_words", wdf_words, 4);
    wr_cmd_valid = 1'b1;
    wr_cmd_bl8   = 1'b1;
    app_wdf_wren = 1'b1;
    tick();
    wr_cmd_valid = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if (k == 8) app_wdf_wren = 1'b0;
      if (k == 4) check("ovl_rden_start", ctrl_wdf_rden, 1);
      if (k == 5) check("ovl_words_k5", wdf_words, 5);
      if (k == 7) check("ovl_words_k7", wdf_words, 5);
      tick();
    end
    check("ovl_words_final", wdf_words, 8);

    // Reset in the second rden cycle
    accept(1'b1);
    repeat (4) tick();
    check("rstmid_rden_before", ctrl_wdf_rden, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_rden_async", ctrl_wdf_rden, 0);
    check("rstmid_words", wdf_words, 0);
    check("rstmid_busy", wr_busy, 0);
    check("rstmid_ready", wr_cmd_ready, 1);
    tick(); tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      seen |= ctrl_wdf_rden | wr_burst_done;
      tick();
    end
    check("rstmid_no_done_rden", seen, 0);
    check("rstmid_words_after", wdf_words, 0);

    // Nine writes with no reads: saturate at DEPTH
    for (int i = 0; i < 9; i++) begin
      app_wdf_wren = 1'b1;
      tick();
    end
    app_wdf_wren = 1'b0;
    repeat (6) tick();
    check("ovf_words_sat", wdf_words, 8);
    check("ovf_err", wdf_err, 32'(exp_err));
    repeat (5) tick();
    check("ovf_err_sticky", wdf_err, 32'(exp_err));
    rst_n = 1'b0;
    tick();
    check("ovf_err_cleared", wdf_err, 0);
    check("ovf_words_cleared", wdf_words, 0);
    rst_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
